// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam logic [1:0]  RD_WORD = 2'b01;
    localparam int unsigned WAIT_W  = 8;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin selector: on a tie, the requester not served last wins.
module rr_arb2 (
    input  logic [1:0] req,   // bit 0 = instruction port, bit 1 = data port
    input  logic       last,  // 1 = data port was granted last
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates a shared memory bus between the instruction-fetch and data ports,
// with round-robin fairness, atomic lock hold and a per-transfer ack timeout.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    output logic          i_err,
    input  logic [1:0]    d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_lock,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          d_err,
    output logic [1:0]    bus_read,
    output logic          bus_write,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,
    output logic          gnt_d
);

    arb_state_t        state, state_nxt;
    logic              last_d, last_d_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              d_req;
    logic              active;
    logic              tmo;
    logic [1:0]        rr_gnt;

    assign d_req  = (d_read != 2'b00) | d_write;
    assign active = ((state == GNT_I) & i_req) | ((state == GNT_D) & d_req);
    assign tmo    = active & ~bus_ack & (wait_cnt == WAIT_W'(TIMEOUT - 1));

    rr_arb2 u_rr_arb2 (
        .req  ({d_req, i_req}),
        .last (last_d),
        .gnt  (rr_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            last_d   <= last_d_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next state, fairness history and wait counter.
    always_comb begin
        state_nxt    = state;
        last_d_nxt   = last_d;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                wait_cnt_nxt = '0;
                if (rr_gnt[1]) begin
                    state_nxt = GNT_D;
                end else if (rr_gnt[0]) begin
                    state_nxt = GNT_I;
                end
            end
            GNT_I: begin
                if (bus_ack | tmo) begin
                    state_nxt    = IDLE;
                    last_d_nxt   = 1'b0;
                    wait_cnt_nxt = '0;
                end else if (!i_req) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            GNT_D: begin
                // A locked sequence keeps the grant across acks and idle gaps.
                if (tmo) begin
                    state_nxt    = IDLE;
                    last_d_nxt   = 1'b1;
                    wait_cnt_nxt = '0;
                end else if (bus_ack) begin
                    wait_cnt_nxt = '0;
                    if (!d_lock) begin
                        state_nxt  = IDLE;
                        last_d_nxt = 1'b1;
                    end
                end else if (!d_req && !d_lock) begin
                    state_nxt    = IDLE;
                    wait_cnt_nxt = '0;
                end else if (d_req) begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Bus command and response routing follow the current grant.
    always_comb begin
        bus_read  = 2'b00;
        bus_write = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        i_rdata   = '0;
        i_ack     = 1'b0;
        i_err     = 1'b0;
        d_rdata   = '0;
        d_ack     = 1'b0;
        d_err     = 1'b0;
        gnt_d     = 1'b0;
        case (state)
            GNT_I: begin
                bus_read = RD_WORD;
                bus_addr = i_addr;
                i_rdata  = bus_rdata;
                i_ack    = bus_ack | tmo;
                i_err    = tmo;
            end
            GNT_D: begin
                bus_read  = d_read;
                bus_write = d_write;
                bus_addr  = d_addr;
                bus_wdata = d_wdata;
                d_rdata   = bus_rdata;
                d_ack     = bus_ack | tmo;
                d_err     = tmo;
                gnt_d     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
